// File: rtl/issue_queue.sv
// In-order issue queue between decode and execute: a small circular FIFO
// whose head issues only when a register scoreboard shows no pending hazard.
module issue_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic [4:0]               in_rd,
   input  logic                     in_use_rs2,
   input  logic                     in_regwrite,
   input  logic [31:0]              in_imm,
   input  logic                     in_alusrc,
   input  logic [1:0]               in_aluop,
   input  logic [9:0]               in_funct,
   output logic                     ex_valid,
   input  logic                     ex_ready,
   output logic [4:0]               ex_rs1,
   output logic [4:0]               ex_rs2,
   output logic [4:0]               ex_rd,
   output logic                     ex_regwrite,
   output logic [31:0]              ex_imm,
   output logic                     ex_alusrc,
   output logic [1:0]               ex_aluop,
   output logic [9:0]               ex_funct,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_rd,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        use_rs2;
      logic        regwrite;
      logic [31:0] imm;
      logic        alusrc;
      logic [1:0]  aluop;
      logic [9:0]  funct;
   } entry_t;

   entry_t          mem_reg [DEPTH];
   logic [PW-1:0]   head_reg, tail_reg;
   logic [CW-1:0]   count_reg;
   logic [31:0]     busy_reg, busy_next;
   entry_t          head_entry, in_entry;
   logic            hazard, push, issue;

   assign head_entry = mem_reg[head_reg];
   assign in_entry   = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, use_rs2: in_use_rs2,
                         regwrite: in_regwrite, imm: in_imm, alusrc: in_alusrc,
                         aluop: in_aluop, funct: in_funct};

   // Only the registered scoreboard is consulted; a writeback this cycle helps next cycle.
   assign hazard = ((head_entry.rs1 != 5'd0) && busy_reg[head_entry.rs1]) ||
                   (head_entry.use_rs2 && (head_entry.rs2 != 5'd0) && busy_reg[head_entry.rs2]) ||
                   (head_entry.regwrite && (head_entry.rd != 5'd0) && busy_reg[head_entry.rd]);

   assign in_ready = (count_reg != CW'(DEPTH)) && !flush;
   assign ex_valid = (count_reg != '0) && !hazard && !flush;
   assign push     = in_valid && in_ready;
   assign issue    = ex_valid && ex_ready;

   assign ex_rs1      = head_entry.rs1;
   assign ex_rs2      = head_entry.rs2;
   assign ex_rd       = head_entry.rd;
   assign ex_regwrite = head_entry.regwrite;
   assign ex_imm      = head_entry.imm;
   assign ex_alusrc   = head_entry.alusrc;
   assign ex_aluop    = head_entry.aluop;
   assign ex_funct    = head_entry.funct;
   assign count       = count_reg;

   // Issue-set is applied after writeback-clear so a coincident set wins.
   always_comb begin
      busy_next = busy_reg;
      if (wb_valid)
         busy_next[wb_rd] = 1'b0;
      if (issue && head_entry.regwrite && (head_entry.rd != 5'd0))
         busy_next[head_entry.rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         busy_reg  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_reg[i] <= '0;
      end else begin
         busy_reg <= busy_next;
         if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
         end else begin
            if (push) begin
               mem_reg[tail_reg] <= in_entry;
               tail_reg          <= tail_reg + PW'(1);
            end
            if (issue)
               head_reg <= head_reg + PW'(1);
            count_reg <= count_reg + CW'(push) - CW'(issue);
         end
      end
   end
endmodule

// File: tb/tb_issue_queue.sv
// Cycle-table bench for issue_queue: per-cycle expected handshake/count values
// plus a scoreboard of accepted instructions compared against each issue.
module tb_issue_queue;
   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        use2;
      logic        rw;
      logic [31:0] imm;
      logic        alusrc;
      logic [1:0]  aluop;
      logic [9:0]  funct;
   } instr_t;

   typedef struct {
      logic       rst, fl, iv;
      instr_t     ins;
      logic       er, wv;
      logic [4:0] wrd;
      logic       eir, eev;
      logic [2:0] ecnt;
      logic       chk, chkz;
   } vec_t;

   logic clock = 1'b0;
   logic reset, in_valid, in_ready, in_use_rs2, in_regwrite, in_alusrc;
   logic [4:0] in_rs1, in_rs2, in_rd, ex_rs1, ex_rs2, ex_rd, wb_rd;
   logic [31:0] in_imm, ex_imm;
   logic [1:0] in_aluop, ex_aluop;
   logic [9:0] in_funct, ex_funct;
   logic ex_valid, ex_ready, ex_regwrite, ex_alusrc, wb_valid, flush;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;
   vec_t   vq[$];
   instr_t sb[$];

   always #5 clock = ~clock;

   issue_queue #(.DEPTH(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_use_rs2(in_use_rs2),
      .in_regwrite(in_regwrite), .in_imm(in_imm), .in_alusrc(in_alusrc),
      .in_aluop(in_aluop), .in_funct(in_funct), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_imm(ex_imm), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .count(count)
   );

   task automatic check(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic instr_t mk(input logic [4:0] rs1, rs2, rd, input logic use2, rw,
                                 input logic [31:0] imm, input logic alusrc,
                                 input logic [1:0] aluop, input logic [9:0] funct);
      mk = '{rs1: rs1, rs2: rs2, rd: rd, use2: use2, rw: rw, imm: imm,
             alusrc: alusrc, aluop: aluop, funct: funct};
   endfunction

   function automatic instr_t nop_i(input int k);
      nop_i = mk(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'(k), 1'b1, 2'd0, 10'd0);
   endfunction

   function automatic instr_t rd5(input int k);
      rd5 = mk(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'(k), 1'b1, 2'd0, 10'd0);
   endfunction

   task automatic add(input logic rst, fl, iv, input instr_t ins, input logic er, wv,
                      input logic [4:0] wrd, input logic eir, eev, input logic [2:0] ecnt,
                      input logic chk, input logic chkz = 1'b0);
      vec_t v;
      v = '{rst: rst, fl: fl, iv: iv, ins: ins, er: er, wv: wv, wrd: wrd,
            eir: eir, eev: eev, ecnt: ecnt, chk: chk, chkz: chkz};
      vq.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t add3, sub4, w5, z;
      instr_t exp_i, got_i;
      add3 = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h0, 1'b0, 2'd2, 10'h000);
      sub4 = mk(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0, 2'd2, 10'h100);
      w5   = mk(5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 32'h55, 1'b1, 2'd0, 10'd0);
      z    = '0;

      //  rst fl iv ins        er wv wrd   eir eev cnt chk
      add(1, 0, 0, z,         0, 0, 0,    0, 0, 0, 0);
      add(0, 0, 0, z,         0, 0, 0,    1, 0, 0, 1, 1);
      add(0, 0, 1, add3,      1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 1, 1);   // ADD issues, busy[3]
      add(0, 0, 1, sub4,      1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 0, 1, 1);   // SUB blocked on x3
      add(0, 0, 0, z,         1, 1, 3,    1, 0, 1, 1);   // no same-cycle bypass
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 1, 1);   // SUB issues
      add(0, 0, 0, z,         0, 1, 4,    1, 0, 0, 1);
      add(0, 0, 1, nop_i(1),  0, 0, 0,    1, 0, 0, 1);   // fill with ex_ready=0
      add(0, 0, 1, nop_i(2),  0, 0, 0,    1, 1, 1, 1);
      add(0, 0, 1, nop_i(3),  0, 0, 0,    1, 1, 2, 1);
      add(0, 0, 1, nop_i(4),  0, 0, 0,    1, 1, 3, 1);
      add(0, 0, 1, nop_i(5),  0, 0, 0,    0, 1, 4, 1);
      add(0, 0, 1, nop_i(5),  0, 0, 0,    0, 1, 4, 1);
      add(0, 0, 1, nop_i(5),  1, 0, 0,    0, 1, 4, 1);   // pop only, no push
      add(0, 0, 1, nop_i(5),  0, 0, 0,    1, 1, 3, 1);   // push into wrapped slot
      add(0, 0, 0, z,         0, 0, 0,    0, 1, 4, 1);
      add(0, 0, 0, z,         1, 0, 0,    0, 1, 4, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 3, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 2, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 1, 1);
      add(0, 0, 0, z,         0, 0, 0,    1, 0, 0, 1);
      add(0, 0, 1, nop_i(6),  1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 1, nop_i(7),  1, 0, 0,    1, 1, 1, 1);   // push+issue, count holds
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 1, 1);
      add(0, 0, 0, z,         0, 0, 0,    1, 0, 0, 1);
      add(0, 0, 1, w5,        1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 1, 1);   // busy[5] set
      add(0, 0, 1, rd5(10),   1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 1, nop_i(8),  1, 0, 0,    1, 0, 1, 1);
      add(0, 0, 1, nop_i(9),  1, 0, 0,    1, 0, 2, 1);
      add(0, 1, 1, nop_i(11), 1, 0, 0,    0, 0, 3, 1);   // flush beats push
      add(0, 0, 0, z,         1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 1, rd5(12),   1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 0, 1, 1);   // busy[5] survived flush
      add(0, 0, 0, z,         1, 1, 5,    1, 0, 1, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 1, 1);
      add(0, 0, 1, w5,        1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 0, z,         1, 1, 5,    1, 1, 1, 1);   // set beats clear
      add(0, 0, 1, rd5(13),   1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 0, 1, 1);
      add(0, 0, 1, nop_i(14), 0, 0, 0,    1, 0, 1, 1);
      add(1, 0, 0, z,         0, 0, 0,    1, 0, 2, 1);   // reset with count=2
      add(0, 0, 0, z,         1, 0, 0,    1, 0, 0, 1, 1);
      add(0, 0, 1, rd5(15),   1, 0, 0,    1, 0, 0, 1);
      add(0, 0, 0, z,         1, 0, 0,    1, 1, 1, 1);   // busy cleared by reset
      add(0, 0, 0, z,         0, 0, 0,    1, 0, 0, 1);

      reset = 0; flush = 0; in_valid = 0; ex_ready = 0; wb_valid = 0; wb_rd = 0;
      {in_rs1, in_rs2, in_rd, in_use_rs2, in_regwrite, in_imm, in_alusrc, in_aluop, in_funct} = '0;
      @(posedge clock); #1;

      for (int c = 0; c < vq.size(); c++) begin
         vec_t v;
         v = vq[c];
         reset = v.rst; flush = v.fl; in_valid = v.iv; ex_ready = v.er;
         wb_valid = v.wv; wb_rd = v.wrd;
         {in_rs1, in_rs2, in_rd, in_use_rs2, in_regwrite, in_imm, in_alusrc, in_aluop, in_funct} = v.ins;
         @(negedge clock);
         if (v.chk) begin
            check("in_ready", c, 64'(in_ready), 64'(v.eir));
            check("ex_valid", c, 64'(ex_valid), 64'(v.eev));
            check("count", c, 64'(count), 64'(v.ecnt));
         end
         if (v.chkz)
            check("ex_zero_after_reset", c,
                  64'({ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_alusrc, ex_aluop, ex_funct} | ex_imm), 64'(0));
         if (v.chk && v.eev && v.er) begin
            if (sb.size() == 0) begin
               check("sb_underflow", c, 64'(1), 64'(0));
            end else begin
               exp_i = sb.pop_front();
               got_i = '{rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, use2: exp_i.use2, rw: ex_regwrite,
                         imm: ex_imm, alusrc: ex_alusrc, aluop: ex_aluop, funct: ex_funct};
               check("issue_fields", c, 64'(got_i), 64'(exp_i));
               $display("cycle %0d issue rd=%0d imm=%0h aluop=%0d funct=%0h",
                        c, ex_rd, ex_imm, ex_aluop, ex_funct);
            end
         end
         if (v.iv && v.eir && !v.rst)
            sb.push_back(v.ins);
         if (v.rst || v.fl)
            sb.delete();
         @(posedge clock); #1;
      end
      check("sb_empty_at_end", vq.size(), 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, fixed at 4 for this pipeline.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  decode presents an instruction.
REQ-005 in_ready  output  1  queue accepts this cycle.
REQ-006 in_rs1, in_rs2, in_rd  input  5 each  register indices.
REQ-007 in_use_rs2  input  1  instruction reads rs2 (R-type/branch/store).
REQ-008 in_regwrite  input  1  instruction writes rd.
REQ-009 in_imm  input  32  generated immediate.
REQ-010 in_alusrc  input  1; in_aluop  input  2; in_funct  input  10  {funct7,funct3} ALU controls.
REQ-011 ex_valid  output  1  head entry is hazard-free and offered to execute.
REQ-012 ex_ready  input  1  execute accepts the offered entry.
REQ-013 ex_rs1, ex_rs2, ex_rd  output  5 each; ex_regwrite  output  1; ex_imm  output  32; ex_alusrc  output  1; ex_aluop  output  2; ex_funct  output  10  head entry fields.
REQ-014 wb_valid  input  1; wb_rd  input  5  writeback completion, clears scoreboard bit.
REQ-015 flush  input  1  discard all queued entries (branch redirect).
REQ-016 count  output  3  current occupancy, 0..4.

Function
REQ-017 Storage SHALL be a circular FIFO: head/tail pointers 2 bits, wrap 3->0; count 3 bits registered.
REQ-018 in_ready SHALL be (count != 4) && !flush; no push when full, even if a pop occurs that cycle.
REQ-019 Push SHALL occur when in_valid && in_ready: entry written at tail, tail+1, count+1.
REQ-020 Scoreboard: 32-bit busy register; busy[0] SHALL always read 0.
REQ-021 Hazard at head SHALL be: (rs1!=0 && busy[rs1]) || (use_rs2 && rs2!=0 && busy[rs2]) || (regwrite && rd!=0 && busy[rd]); registered busy only, no same-cycle writeback bypass.
REQ-022 ex_valid SHALL be (count!=0) && !hazard && !flush, combinational from registered state.
REQ-023 ex_* data outputs SHALL be driven directly from the head entry regardless of ex_valid.
REQ-024 Issue SHALL occur when ex_valid && ex_ready: head+1, count-1; if ex_regwrite && ex_rd!=0, busy[ex_rd] set next cycle.
REQ-025 Simultaneous push and issue SHALL leave count unchanged and advance both pointers.
REQ-026 wb_valid SHALL clear busy[wb_rd] next cycle; if the same cycle sets that bit by issue, set wins.
REQ-027 Issue SHALL be strictly in order; a hazarded head blocks all younger entries.
REQ-028 Minimum latency: instruction pushed in cycle N SHALL have ex_valid earliest in cycle N+1.
REQ-029 flush SHALL, next cycle, zero count, head and tail; busy is unchanged (in-flight ops still write back); no push or issue in the flush cycle.
REQ-030 Flush SHALL take priority over push, issue and writeback-independent queue updates; writeback clears still apply in a flush cycle.

Reset
REQ-031 On reset: count=0, head=tail=0, busy=0, all entry storage=0; hence in_ready=1, ex_valid=0, all ex_* data outputs=0.
REQ-032 Reset SHALL take priority over flush, push, issue and writeback; entries held mid-operation are discarded.

Verification
REQ-033 Reset, then push ADD x3,x1,x2 (funct=0, aluop=2) with ex_ready=1 -> ex_valid=1 next cycle, ex_rd=3, ex_aluop=2; busy[3]=1 after issue.
REQ-034 Push ADD x3 then SUB x4,x3,x1; no writeback -> SUB held at head, ex_valid=0; pulse wb_valid, wb_rd=3 -> SUB issues the following cycle.
REQ-035 ex_ready=0, push 5 instructions back-to-back -> 4 accepted, in_ready=0 and count=4 after fourth; fifth held until one issue.
REQ-036 Full queue, ex_ready=1 and in_valid=1 same cycle -> one pop, no push, count=3; next cycle push accepted, count back to 4, pointers wrapped correctly.
REQ-037 Three entries queued, busy[5]=1, assert flush -> count=0, ex_valid=0 next cycle, busy[5] still 1; instruction writing x0 never sets busy[0].
REQ-038 Assert reset with count=2 and busy nonzero -> next cycle count=0, busy=0, in_ready=1, ex_valid=0.
